// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU control codes, R-type
// opcodes, forwarding selects and the multi-cycle FSM state.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_ORR,
    ALU_PASS_B,
    ALU_MUL
  } alu_ctrl_e;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_ZERO  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } ex_state_e;

  function automatic alu_ctrl_e decode_alu(input logic [1:0] alu_op, input logic [10:0] opcode);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    if (alu_op == 2'b01) begin
      ctrl = ALU_PASS_B;
    end else if (alu_op == 2'b10) begin
      case (opcode)
        OP_SUB:  ctrl = ALU_SUB;
        OP_AND:  ctrl = ALU_AND;
        OP_ORR:  ctrl = ALU_ORR;
        OP_MUL:  ctrl = ALU_MUL;
        default: ctrl = ALU_ADD;
      endcase
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier retiring BPC bits of op_b per cycle; product
// is valid combinationally in the cycle done is high (includes the last step).
module ex_iter_mul #(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int MUL_CYCLES = XLEN / BPC;
  localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  partial;

  always_comb begin
    partial = a_q * XLEN'(b_q[BPC-1:0]);
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      acc_d  = '0;
      a_d    = op_a;
      b_d    = op_b;
      cnt_d  = CNT_W'(MUL_CYCLES - 1);
      busy_d = 1'b1;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      acc_d = acc_q + partial;
      a_d   = a_q << BPC;
      b_d   = b_q >> BPC;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q + partial;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with forwarding, ALU decode and the EX/MEM register; MUL runs
// on the iterative multiplier and stalls upstream until its product is written.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] read_data_1,
  input  logic [XLEN-1:0] read_data_2,
  input  logic [XLEN-1:0] sign_extend_in,
  input  logic            ALUSrc,
  input  logic [1:0]      ALUOp,
  input  logic [31:0]     instruction,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] EX_MEM_alu_result,
  input  logic [XLEN-1:0] WB_write_back,
  output logic            stall,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_write_data,
  output logic            ex_mem_zero,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_reg_write
);

  ex_state_e       state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            zero_q, zero_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic            rw_lat_q, rw_lat_d;

  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res;
  logic            mul_start, mul_abort, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;
  logic            unused_instr;

  assign unused_instr = ^instruction[20:0];

  always_comb begin
    case (forwardA)
      FWD_REG:   op_a = read_data_1;
      FWD_EXMEM: op_a = EX_MEM_alu_result;
      FWD_WB:    op_a = WB_write_back;
      default:   op_a = '0;
    endcase
    case (forwardB)
      FWD_REG:   op_b = read_data_2;
      FWD_EXMEM: op_b = EX_MEM_alu_result;
      FWD_WB:    op_b = WB_write_back;
      default:   op_b = '0;
    endcase
    alu_b    = ALUSrc ? sign_extend_in : op_b;
    alu_ctrl = decode_alu(ALUOp, instruction[31:21]);
    case (alu_ctrl)
      ALU_SUB:    alu_res = op_a - alu_b;
      ALU_AND:    alu_res = op_a & alu_b;
      ALU_ORR:    alu_res = op_a | alu_b;
      ALU_PASS_B: alu_res = alu_b;
      default:    alu_res = op_a + alu_b;
    endcase
  end

  // Every path not explicitly loading a result leaves a zeroed bubble in EX/MEM.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_abort = 1'b0;
    valid_d   = 1'b0;
    result_d  = '0;
    wdata_d   = '0;
    zero_d    = 1'b0;
    rd_d      = '0;
    rw_d      = 1'b0;
    rd_lat_d  = rd_lat_q;
    rw_lat_d  = rw_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (id_valid && !flush) begin
          if (alu_ctrl == ALU_MUL) begin
            stall     = 1'b1;
            mul_start = 1'b1;
            rd_lat_d  = rd_in;
            rw_lat_d  = reg_write_in;
            state_d   = ST_BUSY;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            wdata_d  = op_b;
            zero_d   = (alu_res == '0);
            rd_d     = rd_in;
            rw_d     = reg_write_in;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          mul_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (mul_done) begin
          valid_d  = 1'b1;
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          rd_d     = rd_lat_q;
          rw_d     = rw_lat_q;
          state_d  = ST_IDLE;
        end else begin
          stall = mul_busy;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      wdata_q  <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      rd_lat_q <= '0;
      rw_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      rd_lat_q <= rd_lat_d;
      rw_lat_q <= rw_lat_d;
    end
  end

  ex_iter_mul #(.XLEN(XLEN), .BPC(BPC)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign ex_mem_valid      = valid_q;
  assign ex_mem_alu_result = result_q;
  assign ex_mem_write_data = wdata_q;
  assign ex_mem_zero       = zero_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_reg_write  = rw_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scenario bench for ex_stage_mc (XLEN=64, BPC=4) with an arithmetic reference model.
module tb_ex_stage_mc;
  localparam int XLEN = 64;
  localparam int BPC = 4;
  localparam int MUL_CYCLES = XLEN / BPC;
  localparam logic [10:0] T_ADD = 11'b10001011000;
  localparam logic [10:0] T_SUB = 11'b11001011000;
  localparam logic [10:0] T_AND = 11'b10001010000;
  localparam logic [10:0] T_ORR = 11'b10101010000;
  localparam logic [10:0] T_MUL = 11'b10011011000;

  logic clk = 1'b0;
  logic reset, id_valid, flush, ALUSrc, reg_write_in;
  logic [XLEN-1:0] read_data_1, read_data_2, sign_extend_in, EX_MEM_alu_result, WB_write_back;
  logic [1:0] ALUOp, forwardA, forwardB;
  logic [31:0] instruction;
  logic [4:0] rd_in;
  logic stall, ex_mem_valid, ex_mem_zero, ex_mem_reg_write;
  logic [XLEN-1:0] ex_mem_alu_result, ex_mem_write_data;
  logic [4:0] ex_mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .flush(flush),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .sign_extend_in(sign_extend_in),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .instruction(instruction), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .forwardA(forwardA), .forwardB(forwardB),
    .EX_MEM_alu_result(EX_MEM_alu_result), .WB_write_back(WB_write_back),
    .stall(stall), .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_write_data(ex_mem_write_data), .ex_mem_zero(ex_mem_zero), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write)
  );

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] fwd_val(input logic [1:0] sel, input logic [63:0] r, exm, wb);
    if (sel == 2'b00) return r;
    if (sel == 2'b10) return exm;
    if (sel == 2'b01) return wb;
    return 64'd0;
  endfunction

  // b is the value the operation consumes (immediate or forwarded operand B)
  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [10:0] opc,
                                          input logic [63:0] a, b);
    if (op == 2'b01) return b;
    if (op == 2'b10) begin
      if (opc == T_SUB) return a - b;
      if (opc == T_AND) return a & b;
      if (opc == T_ORR) return a | b;
      if (opc == T_MUL) return a * b;
    end
    return a + b;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [10:0] opc, input logic [63:0] a, b, imm,
                       input logic src, input logic [1:0] fa, fb, input logic [63:0] exm, wb,
                       input logic [4:0] rd, input logic rw);
    logic [31:0] r;
    r = $urandom();
    id_valid = 1'b1; flush = 1'b0; ALUOp = op; instruction = {opc, r[20:0]};
    read_data_1 = a; read_data_2 = b; sign_extend_in = imm; ALUSrc = src;
    forwardA = fa; forwardB = fb; EX_MEM_alu_result = exm; WB_write_back = wb;
    rd_in = rd; reg_write_in = rw;
  endtask

  // Sample combinational stall, then step past one clock edge.
  task automatic do_alu(output logic st);
    #1 st = stall;
    @(posedge clk); #1;
  endtask

  // Run an already-issued MUL to completion; returns stall count and bubble violations.
  task automatic do_mul(input bit perturb, output int stalls, output int bad);
    logic [31:0] r;
    stalls = 0; bad = 0;
    for (int c = 0; c < 4 * MUL_CYCLES; c++) begin
      #1;
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
      if (ex_mem_valid !== 1'b0 || ex_mem_reg_write !== 1'b0) bad++;
      if (perturb && c == 3) begin
        r = $urandom();
        read_data_1 = rand64(); read_data_2 = rand64(); EX_MEM_alu_result = rand64();
        WB_write_back = rand64(); forwardA = r[1:0]; forwardB = r[3:2];
        rd_in = r[8:4]; reg_write_in = r[9];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    issue(2'b10, T_ADD, 64'd1, 64'd2, 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd4, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 id_valid = 1'b0; reset = 1'b0;
    #1;
    checks++; if (ex_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_mem_valid); end
    checks++; if (ex_mem_alu_result !== 64'd0 || ex_mem_write_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h/%h exp 0", ex_mem_alu_result, ex_mem_write_data); end
    checks++; if (ex_mem_rd !== 5'd0 || ex_mem_reg_write !== 1'b0 || ex_mem_zero !== 1'b0) begin errors++; $display("FAIL reset_ctrl got rd %0d rw %b z %b exp 0", ex_mem_rd, ex_mem_reg_write, ex_mem_zero); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic st;
    issue(2'b10, T_ADD, 64'd5, 64'd7, rand64(), 1'b0, 2'b00, 2'b00, rand64(), rand64(), 5'd3, 1'b1);
    do_alu(st);
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", st); end
    checks++; if (ex_mem_alu_result !== 64'd12 || ex_mem_valid !== 1'b1) begin errors++; $display("FAIL add_result got %h v %b exp 12 v 1", ex_mem_alu_result, ex_mem_valid); end
    checks++; if (ex_mem_zero !== 1'b0 || ex_mem_rd !== 5'd3 || ex_mem_reg_write !== 1'b1) begin errors++; $display("FAIL add_ctrl got z %b rd %0d rw %b exp 0 3 1", ex_mem_zero, ex_mem_rd, ex_mem_reg_write); end
  endtask

  task automatic test_sub_fwd();
    logic st;
    issue(2'b10, T_SUB, 64'd1, 64'd9, rand64(), 1'b0, 2'b10, 2'b00, 64'd9, rand64(), 5'd5, 1'b1);
    do_alu(st);
    checks++; if (ex_mem_alu_result !== 64'd0 || ex_mem_zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %h z %b exp 0 z 1", ex_mem_alu_result, ex_mem_zero); end
    issue(2'b10, T_SUB, 64'd1, 64'd9, rand64(), 1'b0, 2'b10, 2'b11, 64'd9, rand64(), 5'd5, 1'b1);
    do_alu(st);
    checks++; if (ex_mem_alu_result !== 64'd9 || ex_mem_zero !== 1'b0) begin errors++; $display("FAIL sub_fwd_zero got %h z %b exp 9 z 0", ex_mem_alu_result, ex_mem_zero); end
    checks++; if (ex_mem_write_data !== 64'd0) begin errors++; $display("FAIL sub_wdata got %h exp 0", ex_mem_write_data); end
  endtask

  task automatic test_stur();
    logic st;
    issue(2'b00, T_ORR, 64'h100, 64'h55, 64'd16, 1'b1, 2'b00, 2'b01, rand64(), 64'hAB, 5'd7, 1'b0);
    do_alu(st);
    checks++; if (ex_mem_alu_result !== 64'h110) begin errors++; $display("FAIL stur_addr got %h exp 110", ex_mem_alu_result); end
    checks++; if (ex_mem_write_data !== 64'hAB) begin errors++; $display("FAIL stur_wdata got %h exp ab", ex_mem_write_data); end
    checks++; if (ex_mem_reg_write !== 1'b0 || ex_mem_valid !== 1'b1) begin errors++; $display("FAIL stur_ctrl got rw %b v %b exp 0 1", ex_mem_reg_write, ex_mem_valid); end
  endtask

  task automatic test_random_alu();
    logic st, src, rw, want_v;
    logic [1:0] op, fa, fb;
    logic [10:0] opc;
    logic [63:0] a, b, imm, exm, wb, bf, exp_res;
    logic [4:0] rd;
    logic [10:0] opcs [4] = '{T_ADD, T_SUB, T_AND, T_ORR};
    int mode;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) opc = 11'($urandom_range(0, 2047));
      else opc = opcs[$urandom_range(0, 3)];
      if (opc == T_MUL) opc = T_ADD;
      a = rand64(); b = ($urandom_range(0, 3) == 0) ? a : rand64(); imm = rand64();
      exm = rand64(); wb = rand64(); src = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
      issue(op, opc, a, b, imm, src, fa, fb, exm, wb, rd, rw);
      mode = $urandom_range(0, 5);
      if (mode == 0) id_valid = 1'b0;
      if (mode == 1) flush = 1'b1;
      want_v = (mode > 1);
      bf = fwd_val(fb, b, exm, wb);
      exp_res = ref_alu(op, opc, fwd_val(fa, a, exm, wb), src ? imm : bf);
      do_alu(st);
      checks++; if (st !== 1'b0 || ex_mem_valid !== want_v || ex_mem_reg_write !== (want_v & rw)) begin errors++; $display("FAIL rand_ctrl[%0d] got st %b v %b rw %b exp 0 %b %b", i, st, ex_mem_valid, ex_mem_reg_write, want_v, want_v & rw); end
      if (want_v) begin
        checks++; if (ex_mem_alu_result !== exp_res || ex_mem_zero !== (exp_res == 64'd0)) begin errors++; $display("FAIL rand_res[%0d] got %h z %b exp %h", i, ex_mem_alu_result, ex_mem_zero, exp_res); end
        checks++; if (ex_mem_write_data !== bf || ex_mem_rd !== rd) begin errors++; $display("FAIL rand_wd[%0d] got %h rd %0d exp %h rd %0d", i, ex_mem_write_data, ex_mem_rd, bf, rd); end
      end
    end
    id_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_mul();
    int stalls, bad;
    issue(2'b10, T_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, rand64(), 1'b0, 2'b00, 2'b00, rand64(), rand64(), 5'd9, 1'b1);
    do_mul(1'b1, stalls, bad);
    checks++; if (stalls != MUL_CYCLES || bad != 0) begin errors++; $display("FAIL mul_stall got %0d stalls %0d bad bubbles exp %0d 0", stalls, bad, MUL_CYCLES); end
    checks++; if (ex_mem_valid !== 1'b1 || ex_mem_alu_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mul_result got %h v %b exp fffffffffffffffd v 1", ex_mem_alu_result, ex_mem_valid); end
    checks++; if (ex_mem_rd !== 5'd9 || ex_mem_reg_write !== 1'b1 || ex_mem_zero !== 1'b0) begin errors++; $display("FAIL mul_ctrl got rd %0d rw %b z %b exp 9 1 0", ex_mem_rd, ex_mem_reg_write, ex_mem_zero); end
    id_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (ex_mem_valid !== 1'b0) begin errors++; $display("FAIL mul_after got v %b exp 0", ex_mem_valid); end
  endtask

  task automatic test_mul_flush();
    logic st;
    int seen_v;
    issue(2'b10, T_MUL, 64'd11, 64'd13, 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd2, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_accept got stall %b exp 1", stall); end
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    seen_v = 0;
    for (int c = 0; c < 2 * MUL_CYCLES; c++) begin
      if (ex_mem_valid !== 1'b0 || stall !== 1'b0) seen_v++;
      @(posedge clk); #1;
    end
    checks++; if (seen_v != 0) begin errors++; $display("FAIL flush_discard got %0d cycles with valid/stall exp 0", seen_v); end
    issue(2'b10, T_ADD, 64'd20, 64'd22, 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd1, 1'b1);
    do_alu(st);
    checks++; if (st !== 1'b0 || ex_mem_alu_result !== 64'd42 || ex_mem_valid !== 1'b1) begin errors++; $display("FAIL flush_next_add got %h v %b st %b exp 42 1 0", ex_mem_alu_result, ex_mem_valid, st); end
    id_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic st;
    int stalls, bad;
    issue(2'b10, T_ADD, 64'd3, 64'd4, 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd6, 1'b1);
    do_alu(st);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; id_valid = 1'b0;
    #1;
    checks++; if (ex_mem_valid !== 1'b0 || ex_mem_alu_result !== 64'd0 || ex_mem_rd !== 5'd0 || ex_mem_reg_write !== 1'b0) begin errors++; $display("FAIL reset_over_accept got v %b r %h rd %0d rw %b exp 0", ex_mem_valid, ex_mem_alu_result, ex_mem_rd, ex_mem_reg_write); end
    @(posedge clk); #1;
    issue(2'b10, T_MUL, rand64(), rand64(), 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd8, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
    #1;
    checks++; if (ex_mem_valid !== 1'b0 || ex_mem_alu_result !== 64'd0 || ex_mem_zero !== 1'b0 || ex_mem_rd !== 5'd0) begin errors++; $display("FAIL reset_mid_out got v %b r %h z %b rd %0d exp 0", ex_mem_valid, ex_mem_alu_result, ex_mem_zero, ex_mem_rd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (ex_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_idle got v %b exp 0", ex_mem_valid); end
    issue(2'b10, T_MUL, 64'd6, 64'd7, 64'd0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 5'd10, 1'b1);
    do_mul(1'b0, stalls, bad);
    checks++; if (stalls != MUL_CYCLES || ex_mem_alu_result !== 64'd42 || ex_mem_valid !== 1'b1) begin errors++; $display("FAIL reset_then_mul got %h stalls %0d v %b exp 42 %0d 1", ex_mem_alu_result, stalls, ex_mem_valid, MUL_CYCLES); end
    id_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int stalls, bad;
    logic [63:0] a, b, exm, wb, exp_res;
    logic [1:0] fa, fb;
    for (int i = 0; i < 4; i++) begin
      a = rand64(); b = (i == 0) ? 64'd0 : rand64(); exm = rand64(); wb = rand64();
      fa = 2'($urandom_range(0, 2)); fb = 2'($urandom_range(0, 2));
      issue(2'b10, T_MUL, a, b, rand64(), 1'($urandom_range(0, 1)), fa, fb, exm, wb, 5'(i + 12), 1'b1);
      exp_res = ref_alu(2'b10, T_MUL, fwd_val(fa, a, exm, wb), fwd_val(fb, b, exm, wb));
      do_mul(i[0], stalls, bad);
      checks++; if (stalls != MUL_CYCLES || bad != 0) begin errors++; $display("FAIL b2b_stall[%0d] got %0d bad %0d exp %0d 0", i, stalls, bad, MUL_CYCLES); end
      checks++; if (ex_mem_valid !== 1'b1 || ex_mem_alu_result !== exp_res || ex_mem_zero !== (exp_res == 64'd0) || ex_mem_rd !== 5'(i + 12)) begin errors++; $display("FAIL b2b_res[%0d] got %h z %b rd %0d exp %h", i, ex_mem_alu_result, ex_mem_zero, ex_mem_rd, exp_res); end
    end
    id_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0; ALUSrc = 1'b0; ALUOp = 2'b00;
    instruction = '0; read_data_1 = '0; read_data_2 = '0; sign_extend_in = '0;
    forwardA = 2'b00; forwardB = 2'b00; EX_MEM_alu_result = '0; WB_write_back = '0;
    rd_in = '0; reg_write_in = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub_fwd();
    test_stur();
    test_random_alu();
    test_mul();
    test_mul_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage for the pipelined ARMv8 core, sitting between the ID/EX and EX/MEM pipeline registers; the EX/MEM register lives inside this block.
- Performs operand forwarding and ALU control decode.
- Single-cycle ALU ops complete in one cycle; MUL runs on an iterative multiplier that stalls upstream until the product is written into EX/MEM.

Parameters:
XLEN, 64, datapath width (must be a multiple of BPC)
BPC, 1, multiplier bits retired per cycle; MUL_CYCLES = XLEN/BPC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID/EX holds a valid instruction
flush  in  1  kill current EX work (branch taken)
read_data_1  in  XLEN  register operand A
read_data_2  in  XLEN  register operand B
sign_extend_in  in  XLEN  immediate
ALUSrc  in  1  1 selects immediate for ALU input B
ALUOp  in  2  main-control ALU class
instruction  in  32  instruction word; [31:21] decoded
rd_in  in  5  destination register
reg_write_in  in  1  destination write enable
forwardA  in  2  forwarding select for operand A
forwardB  in  2  forwarding select for operand B
EX_MEM_alu_result  in  XLEN  forwarded EX/MEM value
WB_write_back  in  XLEN  forwarded WB value
stall  out  1  hold ID/EX and earlier stages
ex_mem_valid  out  1  EX/MEM holds a valid result
ex_mem_alu_result  out  XLEN  registered result
ex_mem_write_data  out  XLEN  registered store data
ex_mem_zero  out  1  registered result == 0
ex_mem_rd  out  5  registered destination
ex_mem_reg_write  out  1  registered write enable (0 when invalid)

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset: all ex_mem_* outputs are 0, FSM goes to IDLE, stall is 0. Reset overrides flush and accept.
- Forward select, per operand, in binary: 2'b00 register, 2'b10 EX_MEM_alu_result, 2'b01 WB_write_back, 2'b11 zero.
- B is forwarded before the ALUSrc mux. Store data is the forwarded B, never the immediate.
- ALU control:
  - ALUOp 00 and 11: ADD.
  - ALUOp 01: PASS_B (CBZ).
  - ALUOp 10 decodes instruction[31:21]:
    - 10001011000 ADD
    - 11001011000 SUB
    - 10001010000 AND
    - 10101010000 ORR
    - 10011011000 MUL
    - any other opcode: ADD.
- Arithmetic wraps modulo 2^XLEN. MUL yields the low XLEN bits of the product (identical for signed and unsigned).
- Zero flag = (result == 0), registered with the result.
- FSM IDLE:
  - id_valid && !flush && non-MUL: at the clock edge, EX/MEM loads the result, valid=1, rd_in and reg_write_in. stall=0.
  - id_valid && !flush && MUL: stall=1 combinationally. Latch the forwarded operands, load cnt=MUL_CYCLES-1, clear the accumulator, go to BUSY. EX/MEM loads a bubble.
  - !id_valid or flush: EX/MEM loads a bubble (valid=0, reg_write=0, other fields don't-care but held at 0).
- FSM BUSY:
  - Each cycle, retire BPC multiplier bits into the accumulator; cnt decrements.
  - stall=1 while cnt!=0; EX/MEM loads a bubble.
  - cnt==0: stall=0. At the edge, EX/MEM loads the product, zero flag, latched rd and reg_write with valid=1; go to IDLE. The still-present MUL on the inputs is ignored that cycle.
- Latency: non-MUL takes 1 cycle. MUL takes MUL_CYCLES+1 cycles from accept to EX/MEM valid, with exactly MUL_CYCLES cycles of stall.
- Operands are latched at accept, so forwarding-source changes during BUSY have no effect.
- Flush in BUSY: abort to IDLE, stall=0 that cycle, EX/MEM loads a bubble, the product is discarded.
- Flush with reset: reset wins.
- Back-to-back MULs: the second is accepted in the cycle after the first result is written (no gap beyond the stall).

Decomposition:
- Shared package ex_pkg holds:
  - ALU control codes (ADD, SUB, AND, ORR, PASS_B, MUL)
  - R-type opcode constants
  - forward-select encodings
  - FSM state enum
- One sub-module, ex_iter_mul (XLEN, BPC): start, operands, busy/done, product.
- ALU and decode stay inline.

Test Plan:
- XLEN=64, ALUOp=10, ADD opcode, A=5, B=7, forward 00 -> next cycle ex_mem_alu_result=12, valid=1, zero=0, stall never 1.
- SUB A=9, B=9, forwardA=10 with EX_MEM_alu_result=9 -> result 0, zero=1. Repeat with forwardB=11 -> result 9.
- STUR (ALUOp 00, ALUSrc=1, imm=16, read_data_1=0x100, forwardB=01, WB=0xAB) -> result 0x110, write_data=0xAB.
- BPC=4, MUL A=0xFFFF_FFFF_FFFF_FFFF, B=3 -> stall high exactly 16 cycles, 16 bubbles, then result 0xFFFF_FFFF_FFFF_FFFD, valid=1. Changing forward inputs mid-busy has no effect.
- MUL accepted, flush asserted in busy cycle 5 -> stall drops that cycle, no valid result ever appears. Next ADD completes normally.
- reset asserted mid-MUL and together with flush -> next cycle all outputs 0, IDLE. A MUL issued after reset gives the correct product 6*7=42.
